seq_detector_param: RTL

Parametrised serial pattern detector that samples a one-bit stream and raises a registered Moore match flag when the last `N` bits equal a runtime-programmable pattern under a don't-care mask. It supports overlapping and non-overlapping modes and an optional saturating match counter. It is the general-purpose successor to our fixed 7-bit detector. It sits directly on a synchronised serial input and feeds control logic or a status register.

---
 rtl/seq_det_pkg.sv | 11 +
 rtl/seq_det_hist.sv | 40 ++++
 rtl/seq_detector_param.sv | 79 +++++++
 3 files changed

// File: rtl/seq_det_pkg.sv
// Shared constants and helpers for the parametrised serial pattern detector.
package seq_det_pkg;

  localparam logic [6:0] DEF_PAT7 = 7'b0111110;

  // Width needed to hold a fill count in the range 0..n.
  function automatic int fill_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/seq_det_hist.sv
// History shift register plus saturating fill counter for seq_detector_param.
// hist_next/fill_next are the post-shift values so the parent can compare them this cycle.
module seq_det_hist
  import seq_det_pkg::*;
#(
  parameter int N = 7,
  localparam int FW = fill_w(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          shift,
  input  logic          bit_in,
  input  logic          clr,
  output logic [N-1:0]  hist_next,
  output logic [FW-1:0] fill_next,
  output logic [N-1:0]  hist,
  output logic [FW-1:0] fill
);

  always_comb begin
    hist_next = hist;
    fill_next = fill;
    if (shift) begin
      hist_next = {hist[N-2:0], bit_in};
      if (fill != FW'(N)) fill_next = fill + FW'(1);
    end
  end

  // clr invalidates the history without touching its contents.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist <= '0;
      fill <= '0;
    end else begin
      hist <= hist_next;
      fill <= clr ? '0 : fill_next;
    end
  end

endmodule

// File: rtl/seq_detector_param.sv
// Serial pattern detector with runtime pattern/mask and registered Moore match flag w.
// Define SEQDET_COUNT_EN to add the saturating match counter and its count port.
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int             N        = 7,
  parameter logic [N-1:0]   DEF_PAT  = N'(DEF_PAT7),
  parameter logic [N-1:0]   DEF_MASK = {N{1'b1}},
  parameter int             CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             j,
  input  logic             load,
  input  logic [N-1:0]     pat_in,
  input  logic [N-1:0]     mask_in,
  input  logic             overlap,
  output logic             w
`ifdef SEQDET_COUNT_EN
  ,
  output logic [CNT_W-1:0] count
`endif
);

  localparam int FW = fill_w(N);

  logic [N-1:0]  pat;
  logic [N-1:0]  mask;
  logic [N-1:0]  hist_next;
  logic [FW-1:0] fill_next;
  logic [N-1:0]  hist;
  logic [FW-1:0] fill;
  logic          shift;
  logic          match;
  logic          clr;

  // load wins over en, so a bit presented with load is never shifted in.
  assign shift = en & ~load;
  assign match = shift && (((hist_next ^ pat) & mask) == '0) && (fill_next == FW'(N));
  assign clr   = load | (match & ~overlap);

  seq_det_hist #(.N(N)) u_hist (
    .clk       (clk),
    .rst       (rst),
    .shift     (shift),
    .bit_in    (j),
    .clr       (clr),
    .hist_next (hist_next),
    .fill_next (fill_next),
    .hist      (hist),
    .fill      (fill)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pat  <= DEF_PAT;
      mask <= DEF_MASK;
      w    <= 1'b0;
    end else begin
      w <= match;
      if (load) begin
        pat  <= pat_in;
        mask <= mask_in;
      end
    end
  end

`ifdef SEQDET_COUNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (match && (count != {CNT_W{1'b1}})) begin
      count <= count + CNT_W'(1);
    end
  end
`endif

endmodule
